mont_reduce_arbiter: RTL and testbench

//  Shares one pipelined Dilithium Montgomery reduction datapath between two requesters
//  (butterfly lanes 0 and 1). Arbitration is round-robin, and each operand carries a

---
 rtl/mont_reduce_arbiter_if.sv | 26 ++
 rtl/mont_reduce_arbiter.sv | 100 ++++++++++
 tb/tb_mont_reduce_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_reduce_arbiter_if.sv
// Operand/result bundle between the two butterfly lanes and the shared Montgomery reducer.
// The master side belongs to the lanes; the slave side belongs to the reducer.
interface mont_reduce_arbiter_if;
    logic        stall;
    logic        req0_valid;
    logic [63:0] req0_a;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_a;
    logic        req1_ready;
    logic        res0_valid;
    logic [31:0] res0_data;
    logic        res1_valid;
    logic [31:0] res1_data;
    logic        busy;

    modport master (
        output stall, req0_valid, req0_a, req1_valid, req1_a,
        input  req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data, busy
    );

    modport slave (
        input  stall, req0_valid, req0_a, req1_valid, req1_a,
        output req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data, busy
    );
endinterface

// File: rtl/mont_reduce_arbiter.sv
// Round-robin shared 3-stage Dilithium Montgomery reducer; each operand carries a lane tag
// so its result pulses only on the lane that issued it.
module mont_reduce_arbiter #(
    parameter logic [31:0] DIL_Q = 32'd8380417,
    parameter logic [31:0] QINV  = 32'd58728449
) (
    input  logic                  clk,
    input  logic                  rst,
    mont_reduce_arbiter_if.slave  bus
);
    localparam int WIDTH = 32;

    logic             rr_ptr;
    logic             grant0;
    logic             grant1;

    logic             s1_v;
    logic             s1_tag;
    logic [63:0]      s1_a;
    logic             s2_v;
    logic             s2_tag;
    logic [63:0]      s2_a;
    logic [31:0]      s2_t;
    logic             s3_v;
    logic             s3_tag;
    logic [WIDTH-1:0] res0_q;
    logic [WIDTH-1:0] res1_q;

    logic [31:0]      t_next;
    logic [63:0]      r_full;
    logic [WIDTH-1:0] r_next;

    // Lane rr_ptr wins only when both lanes contend; stall withdraws every grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!bus.stall) begin
            grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
            grant1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr);
        end
    end

    // Low 32 bits of a - t*q are zero by construction, so the high half is the exact quotient.
    always_comb begin
        t_next = s1_a[31:0] * QINV;
        r_full = s2_a - ({{32{s2_t[31]}}, s2_t} * {32'd0, DIL_Q});
        r_next = WIDTH'(r_full >> 32);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Whole pipeline moves in lockstep; bubbles advance too so latency is fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_tag <= 1'b0;
            s1_a   <= '0;
            s2_v   <= 1'b0;
            s2_tag <= 1'b0;
            s2_a   <= '0;
            s2_t   <= '0;
            s3_v   <= 1'b0;
            s3_tag <= 1'b0;
            res0_q <= '0;
            res1_q <= '0;
        end else if (!bus.stall) begin
            s1_v   <= grant0 | grant1;
            s1_tag <= grant1;
            s1_a   <= grant1 ? bus.req1_a : bus.req0_a;
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            s2_a   <= s1_a;
            s2_t   <= t_next;
            s3_v   <= s2_v;
            s3_tag <= s2_tag;
            if (s2_v && !s2_tag) begin
                res0_q <= r_next;
            end
            if (s2_v && s2_tag) begin
                res1_q <= r_next;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res0_valid = s3_v & ~s3_tag & ~bus.stall;
    assign bus.res1_valid = s3_v &  s3_tag & ~bus.stall;
    assign bus.res0_data  = res0_q;
    assign bus.res1_data  = res1_q;
    assign bus.busy       = s1_v | s2_v | s3_v;
endmodule

// File: tb/tb_mont_reduce_arbiter.sv
// Directed and randomised bench for mont_reduce_arbiter, checked against a queue-based
// reference model that tracks each accepted operand's age in non-stalled cycles.
module tb_mont_reduce_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mont_reduce_arbiter_if bus();

    mont_reduce_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit     lane;
        longint val;
        int     age;
    } ent_t;

    ent_t   pipe_q[$];
    bit     m_rr = 1'b0;
    bit     m_g0 = 1'b0;
    bit     m_g1 = 1'b0;
    longint last_data[2] = '{0, 0};
    longint res0_log[$];

    function automatic longint model_reduce(input longint a);
        int t;
        t = int'(a * 64'sd58728449);
        return (a - longint'(t) * 64'sd8380417) >>> 32;
    endfunction

    function automatic longint rand_a();
        longint m;
        m = (longint'($urandom_range(0, 8380000)) <<< 31) + longint'($urandom_range(0, 32'h7fffffff));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    task automatic check_output(input string name, input logic signed [63:0] actual,
                                input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v0, input logic [63:0] a0, input bit v1,
                                  input logic [63:0] a1, input bit st);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.stall      = st;
    endtask

    // Reference model: an operand emits on the second non-stalled edge after its accept edge.
    always @(posedge clk or posedge rst) begin
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (rst) begin
            pipe_q.delete();
            m_rr = 1'b0;
            last_data[0] = 0;
            last_data[1] = 0;
        end else if (!bus.stall) begin
            m_g0 = bus.req0_valid && (!bus.req1_valid || !m_rr);
            m_g1 = bus.req1_valid && !m_g0;
            foreach (pipe_q[i]) begin
                pipe_q[i].age++;
                if (pipe_q[i].age == 2) last_data[pipe_q[i].lane] = pipe_q[i].val;
            end
            while (pipe_q.size() > 0 && pipe_q[0].age > 2) void'(pipe_q.pop_front());
            if (m_g0) begin
                pipe_q.push_back('{lane: 1'b0, val: model_reduce(bus.req0_a), age: 0});
                m_rr = 1'b1;
            end else if (m_g1) begin
                pipe_q.push_back('{lane: 1'b1, val: model_reduce(bus.req1_a), age: 0});
                m_rr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit e_v0;
        bit e_v1;
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        foreach (pipe_q[i]) begin
            if (pipe_q[i].age == 2 && !bus.stall) begin
                if (pipe_q[i].lane) e_v1 = 1'b1;
                else                e_v0 = 1'b1;
            end
        end
        check_output("req0_ready", bus.req0_ready,
                     !bus.stall && bus.req0_valid && (!bus.req1_valid || !m_rr));
        check_output("req1_ready", bus.req1_ready,
                     !bus.stall && bus.req1_valid && (!bus.req0_valid || m_rr));
        check_output("res0_valid", bus.res0_valid, e_v0);
        check_output("res1_valid", bus.res1_valid, e_v1);
        check_output("res0_data", $signed(bus.res0_data), last_data[0]);
        check_output("res1_data", $signed(bus.res1_data), last_data[1]);
        check_output("busy", bus.busy, pipe_q.size() != 0);
        if (bus.res0_valid === 1'b1) res0_log.push_back(longint'($signed(bus.res0_data)));
    end

    initial begin
        longint a0s[6];
        longint a1s[6];
        longint ops[4];
        int     idx0;
        int     idx1;
        int     lat;
        bit     st;
        bit     v0;
        bit     v1;
        longint ra0;
        longint ra1;

        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_output("model_2pow32", model_reduce(64'sh1_0000_0000), 1);
        check_output("model_q", model_reduce(64'sd8380417), 0);
        check_output("model_negq", model_reduce(-64'sd8380417), 0);
        check_output("model_neg2pow32", model_reduce(-64'sh1_0000_0000), -1);

        // Single lane-0 operand: latency and literal result.
        apply_stimulus(1, 64'h1_0000_0000, 0, 0, 0);
        @(posedge clk); #1;
        check_output("t1_accept", m_g0, 1);
        apply_stimulus(0, 0, 0, 0, 0);
        lat = 1;
        while (bus.res0_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output("t1_latency", lat, 3);
        check_output("t1_data", $signed(bus.res0_data), 1);
        check_output("t1_res1_quiet", bus.res1_valid, 0);
        repeat (2) @(posedge clk); #1;

        // Lane 1 with +q and -q back to back.
        apply_stimulus(0, 0, 1, 64'sd8380417, 0);
        @(posedge clk); #1;
        apply_stimulus(0, 0, 1, -64'sd8380417, 0);
        @(posedge clk); #1;
        apply_stimulus(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_output("t2_pos_valid", bus.res1_valid, 1);
        check_output("t2_pos_data", $signed(bus.res1_data), 0);
        @(posedge clk); #1;
        check_output("t2_neg_valid", bus.res1_valid, 1);
        check_output("t2_neg_data", $signed(bus.res1_data), 0);
        repeat (2) @(posedge clk); #1;

        // Both lanes contending from a fresh reset.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a0s[i] = 64'sh1_0000_0000 * (i + 10);
            a1s[i] = -64'sh1_0000_0000 * (i + 20);
        end
        idx0 = 0;
        idx1 = 0;
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(1, a0s[idx0], 1, a1s[idx1], 0);
            @(posedge clk); #1;
            check_output("t3_grant_lane", m_g1, c % 2);
            if (m_g0) idx0++;
            if (m_g1) idx1++;
        end
        apply_stimulus(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk); #1;

        // Lane-0 stream with a two-cycle stall in the middle.
        ops = '{64'sh2_0000_0000, 64'sh3_0000_0000, 64'sh4_0000_0000, 64'sh5_0000_0000};
        res0_log.delete();
        idx0 = 0;
        for (int c = 0; c < 12; c++) begin
            st = (c == 2 || c == 3);
            apply_stimulus(idx0 < 4, (idx0 < 4) ? ops[idx0] : 64'd0, 0, 0, st);
            @(negedge clk);
            if (st) begin
                check_output("t4_stall_ready", bus.req0_ready, 0);
                check_output("t4_stall_res", bus.res0_valid, 0);
            end
            @(posedge clk); #1;
            if (m_g0) idx0++;
        end
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("t4_accepted", idx0, 4);
        check_output("t4_count", res0_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_output("t4_order", (i < res0_log.size()) ? res0_log[i] : -999, i + 2);
        end

        // Reset with three operands in flight.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 64'sh1_0000_0000 * (i + 7), 0, 0, 0);
            @(posedge clk); #1;
        end
        check_output("t5_full_before", bus.busy, 1);
        apply_stimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_output("t5_res0_valid", bus.res0_valid, 0);
        check_output("t5_res1_valid", bus.res1_valid, 0);
        check_output("t5_res0_data", bus.res0_data, 0);
        check_output("t5_res1_data", bus.res1_data, 0);
        check_output("t5_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        apply_stimulus(1, 64'sh1_0000_0000, 1, 64'sh2_0000_0000, 0);
        @(negedge clk);
        check_output("t5_rr_lane0", bus.req0_ready, 1);
        check_output("t5_rr_lane1", bus.req1_ready, 0);
        @(posedge clk); #1;
        apply_stimulus(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk); #1;

        // Random operands on both lanes with occasional stalls; operands held until accepted.
        v0 = 1'b0;
        v1 = 1'b0;
        ra0 = 0;
        ra1 = 0;
        for (int c = 0; c < 60; c++) begin
            if (!v0 || m_g0) begin
                v0 = ($urandom_range(0, 3) != 0);
                ra0 = rand_a();
            end
            if (!v1 || m_g1) begin
                v1 = ($urandom_range(0, 3) != 0);
                ra1 = rand_a();
            end
            apply_stimulus(v0, ra0, v1, ra1, $urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        apply_stimulus(0, 0, 0, 0, 0);
        repeat (6) @(posedge clk); #1;
        check_output("t6_drained", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
